// File: rtl/cascade_master_drv.sv
// Master end of the 8259A cascade bus: follows the INTA pulse train and drives the
// granted slave's IR level on CAS for the whole acknowledge sequence.
module cascade_master_drv #(
  parameter int SYNC_STAGES = 2,
  parameter int GAP_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       INTAn,
  input  logic       master_mode,
  input  logic       mode_8086,
  input  logic [7:0] icw3,
  input  logic       ir_valid,
  input  logic [2:0] ir_level,
  output logic [2:0] CAS,
  output logic       cas_oe,
  output logic       freeze,
  output logic       vec_oe,
  output logic [1:0] byte_sel,
  output logic       spurious,
  output logic       seq_done,
  output logic       seq_abort,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {IDLE, ACK1, GAP1, ACK2, GAP2, ACK3, DONE} state_t;

  localparam logic [7:0] TIMEOUT = 8'(GAP_TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   intan_s, fall, rise;
  state_t                 state_q, state_d;
  logic [7:0]             gap_cnt_q, gap_cnt_d;
  logic [2:0]             lvl_q, lvl_d;
  logic                   hit_q, hit_d, spur_q, spur_d, m86_q, m86_d;
  logic                   in_gap, timeout, abort_d;
  logic [2:0]             cas_d;
  logic                   cas_oe_d, freeze_d, vec_oe_d, spur_out_d, done_d;
  logic [1:0]             byte_sel_d;

  assign intan_s   = sync_q[SYNC_STAGES-1];
  assign fall      = prev_q & ~intan_s;
  assign rise      = ~prev_q & intan_s;
  assign in_gap    = (state_q == GAP1) || (state_q == GAP2);
  assign timeout   = in_gap && ((gap_cnt_q + 8'd1) == TIMEOUT);
  assign dbg_state = state_q;

  // Sequence tracking; the granted level and mode are captured once, on the first fall.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    lvl_d     = lvl_q;
    hit_d     = hit_q;
    spur_d    = spur_q;
    m86_d     = m86_q;
    abort_d   = 1'b0;
    unique case (state_q)
      IDLE: if (fall) begin
        state_d = ACK1;
        lvl_d   = ir_valid ? ir_level : 3'd7;
        spur_d  = ~ir_valid;
        hit_d   = master_mode & ir_valid & icw3[lvl_d];
        m86_d   = mode_8086;
      end
      ACK1: if (rise) begin
        state_d   = GAP1;
        gap_cnt_d = '0;
      end
      GAP1: begin
        // A fall coinciding with the timeout is dropped: the abort wins.
        if (timeout) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (fall) state_d = ACK2;
        else gap_cnt_d = gap_cnt_q + 8'd1;
      end
      ACK2: if (rise) begin
        if (m86_q) state_d = DONE;
        else begin
          state_d   = GAP2;
          gap_cnt_d = '0;
        end
      end
      GAP2: begin
        if (timeout) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (fall) state_d = ACK3;
        else gap_cnt_d = gap_cnt_q + 8'd1;
      end
      ACK3: if (rise) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so CAS cannot glitch at the pads.
  always_comb begin
    cas_d      = '0;
    cas_oe_d   = 1'b0;
    freeze_d   = 1'b0;
    byte_sel_d = '0;
    spur_out_d = 1'b0;
    done_d     = 1'b0;
    unique case (state_d)
      ACK1, GAP1, ACK2, GAP2, ACK3: begin
        freeze_d   = 1'b1;
        cas_oe_d   = hit_d;
        cas_d      = hit_d ? lvl_d : 3'b000;
        spur_out_d = spur_d;
      end
      DONE: begin
        done_d     = 1'b1;
        spur_out_d = spur_d;
      end
      default: ;
    endcase
    if (state_d == ACK2 || state_d == GAP2) byte_sel_d = 2'd1;
    else if (state_d == ACK3)               byte_sel_d = 2'd2;
    // 8080 puts the CALL opcode out in pulse 1; vector bytes come from the master only without a slave.
    vec_oe_d = ((state_d == ACK1) && !m86_d) ||
               (((state_d == ACK2) || (state_d == ACK3)) && !hit_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '1;
      prev_q    <= 1'b1;
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      lvl_q     <= '0;
      hit_q     <= 1'b0;
      spur_q    <= 1'b0;
      m86_q     <= 1'b0;
      CAS       <= '0;
      cas_oe    <= 1'b0;
      freeze    <= 1'b0;
      vec_oe    <= 1'b0;
      byte_sel  <= '0;
      spurious  <= 1'b0;
      seq_done  <= 1'b0;
      seq_abort <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], INTAn};
      prev_q    <= intan_s;
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      lvl_q     <= lvl_d;
      hit_q     <= hit_d;
      spur_q    <= spur_d;
      m86_q     <= m86_d;
      CAS       <= cas_d;
      cas_oe    <= cas_oe_d;
      freeze    <= freeze_d;
      vec_oe    <= vec_oe_d;
      byte_sel  <= byte_sel_d;
      spurious  <= spur_out_d;
      seq_done  <= done_d;
      seq_abort <= abort_d;
    end
  end

endmodule
